// File: rtl/alu_seg_unit.sv
// rtl/alu_seg_unit.sv - WIDTH-bit ALU with iterative mul/div/mod and multiplexed hex seven-segment display
module alu_seg_unit #(
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 4,
  parameter int REFRESH = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [3:0]        f,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_NOT  = 4'd5;
  localparam logic [3:0] F_SHL  = 4'd6;
  localparam logic [3:0] F_SHR  = 4'd7;
  localparam logic [3:0] F_MUL  = 4'd8;
  localparam logic [3:0] F_DIV  = 4'd9;
  localparam logic [3:0] F_MOD  = 4'd10;
  localparam logic [3:0] F_INC  = 4'd11;
  localparam logic [3:0] F_DEC  = 4'd12;
  localparam logic [3:0] F_PASS = 4'd13;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t state, state_nxt;

  logic                 accept;
  logic                 iter_code;
  logic                 last_step;
  logic [CW-1:0]        cnt;
  logic [3:0]           op_f;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   mcand, prod, prod_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     rem, rem_nxt, quo, quo_nxt;
  logic [WIDTH:0]       rem_sh, rem_dif;
  logic [WIDTH:0]       sum_ext, dif_ext;
  logic [WIDTH-1:0]     sc_res, it_res;
  logic                 sc_c, sc_v, it_c;
  logic [RW-1:0]        refresh_cnt;
  logic [DW-1:0]        digit_idx;
  logic [4*DIGITS-1:0]  res_pad;
  logic [3:0]           nib;

  // Standard hex decode, active-low, bit order g..a
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign iter_code = ((f == F_MUL) || (f == F_DIV) || (f == F_MOD)) && (b != '0);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: enter ITER only for a nonzero-divisor/multiplier iterative code
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && iter_code) state_nxt = S_ITER;
      S_ITER:  if (last_step)          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state == S_ITER);
    accept = (state == S_IDLE) && start;
  end

  // Single-cycle result and carry/overflow for the live inputs
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b};
    dif_ext = {1'b0, a} - {1'b0, b};
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (f)
      F_ADD: begin
        sc_res = sum_ext[WIDTH-1:0];
        sc_c   = sum_ext[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        sc_res = dif_ext[WIDTH-1:0];
        sc_c   = dif_ext[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      F_AND:  sc_res = a & b;
      F_OR:   sc_res = a | b;
      F_XOR:  sc_res = a ^ b;
      F_NOT:  sc_res = ~a;
      F_SHL: begin
        sc_res = {a[WIDTH-2:0], 1'b0};
        sc_c   = a[WIDTH-1];
      end
      F_SHR: begin
        sc_res = {1'b0, a[WIDTH-1:1]};
        sc_c   = a[0];
      end
      // Iterative codes only land here with b == 0
      F_MUL:  sc_res = '0;
      F_DIV: begin
        sc_res = '1;
        sc_v   = 1'b1;
      end
      F_MOD: begin
        sc_res = a;
        sc_v   = 1'b1;
      end
      F_INC:  sc_res = a + WIDTH'(1);
      F_DEC:  sc_res = a - WIDTH'(1);
      F_PASS: sc_res = b;
      default: sc_res = '0;
    endcase
  end

  // One shift-add and one restoring-subtract step, and the final result they produce
  always_comb begin
    prod_nxt = mplier[0] ? (prod + mcand) : prod;
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_dif  = rem_sh - {1'b0, op_b};
    if (!rem_dif[WIDTH]) begin
      rem_nxt = rem_dif[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
    it_c = 1'b0;
    case (op_f)
      F_MUL: begin
        it_res = prod_nxt[WIDTH-1:0];
        it_c   = |prod_nxt[2*WIDTH-1:WIDTH];
      end
      F_DIV:   it_res = quo_nxt;
      default: it_res = rem_nxt;
    endcase
  end

  // Operand capture, iteration datapath and result/flag/done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      cnt    <= '0;
      op_f   <= '0;
      op_b   <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (iter_code) begin
          op_f   <= f;
          op_b   <= b;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          prod   <= '0;
          rem    <= '0;
          quo    <= a;
          cnt    <= '0;
        end else begin
          result <= sc_res;
          flags  <= {sc_v, sc_res[WIDTH-1], sc_c, (sc_res == '0)};
          done   <= 1'b1;
        end
      end else if (busy) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        prod   <= prod_nxt;
        rem    <= rem_nxt;
        quo    <= quo_nxt;
        cnt    <= cnt + CW'(1);
        if (last_step) begin
          result <= it_res;
          flags  <= {1'b0, it_res[WIDTH-1], it_c, (it_res == '0)};
          done   <= 1'b1;
        end
      end
    end
  end

  // Select the nibble of the active digit, zero-padded above WIDTH
  always_comb begin
    res_pad              = '0;
    res_pad[WIDTH-1:0]   = result;
    nib                  = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == DW'(i)) nib = res_pad[4*i +: 4];
    end
  end

  // Free-running refresh counter and registered digit/segment drive
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an          <= ~DIGITS'(1);
      seg         <= 7'b1000000;
    end else begin
      if (refresh_cnt == RW'(REFRESH - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + DW'(1);
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= hex7(nib);
    end
  end

endmodule

// File: tb/tb_alu_seg_unit.sv
// tb/tb_alu_seg_unit.sv - directed scoreboard bench for alu_seg_unit
module tb_alu_seg_unit;

  localparam int W = 8;
  localparam int D = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [3:0]   f;
  logic         start;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [6:0]   seg;
  logic [D-1:0] an;

  alu_seg_unit #(.WIDTH(W), .DIGITS(D), .REFRESH(R)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .f(f), .start(start),
    .busy(busy), .done(done), .result(result), .flags(flags),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
    logic [7:0] lat;
    logic [7:0] bsy;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, push its expectation, wait for done, pop and compare
  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                    input logic [3:0] tf, input logic [7:0] eres, input logic [3:0] eflg,
                    input logic [7:0] elat, input logic [7:0] ebsy, input bit disturb);
    int   cyc;
    int   bcnt;
    bit   got;
    exp_t e;
    sb.push_back('{res: eres, flg: eflg, lat: elat, bsy: ebsy});
    a = ta; b = tb_v; f = tf; start = 1'b1;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (disturb && cyc == 3) begin start = 1'b1; f = 4'd0; a = 8'hFF; b = 8'h01; end
      if (disturb && cyc == 4) start = 1'b0;
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_done"},   32'(got),    32'd1);
    check({tag, "_lat"},    32'(cyc),    32'(e.lat));
    check({tag, "_busy"},   32'(bcnt),   32'(e.bsy));
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_flags"},  32'(flags),  32'(e.flg));
    @(negedge clk);
    check({tag, "_pulse"},  32'(done),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] segexp [4];
    logic [3:0] anexp  [4];
    logic [3:0] prev_an;
    bit         found;
    int         dcnt;
    segexp = '{7'b0010010, 7'b0001000, 7'b1000000, 7'b1000000};
    anexp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; f = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_flags",  32'(flags),  32'h0);
    check("rst_an",     32'(an),     32'b1110);
    check("rst_seg",    32'(seg),    32'b1000000);
    rst = 1'b0;

    op("add",   8'hFF, 8'h01, 4'd0,  8'h00, 4'b0011, 8'd1, 8'd0, 1'b0);
    op("add_v", 8'h7F, 8'h01, 4'd0,  8'h80, 4'b1100, 8'd1, 8'd0, 1'b0);
    op("sub_b", 8'h10, 8'h20, 4'd1,  8'hF0, 4'b0110, 8'd1, 8'd0, 1'b0);
    op("sub_v", 8'h80, 8'h01, 4'd1,  8'h7F, 4'b1000, 8'd1, 8'd0, 1'b0);
    op("shl",   8'h81, 8'h00, 4'd6,  8'h02, 4'b0010, 8'd1, 8'd0, 1'b0);
    op("shr",   8'h01, 8'h00, 4'd7,  8'h00, 4'b0011, 8'd1, 8'd0, 1'b0);
    op("rsv14", 8'h5A, 8'hA5, 4'd14, 8'h00, 4'b0001, 8'd1, 8'd0, 1'b0);
    op("dec",   8'h00, 8'h00, 4'd12, 8'hFF, 4'b0100, 8'd1, 8'd0, 1'b0);
    op("mul",   8'h12, 8'h10, 4'd8,  8'h20, 4'b0010, 8'd9, 8'd8, 1'b1);
    op("div",   8'h64, 8'h07, 4'd9,  8'h0E, 4'b0000, 8'd9, 8'd8, 1'b0);
    op("mod",   8'h64, 8'h07, 4'd10, 8'h02, 4'b0000, 8'd9, 8'd8, 1'b0);
    op("mul0",  8'h12, 8'h00, 4'd8,  8'h00, 4'b0001, 8'd1, 8'd0, 1'b0);
    op("div0",  8'h0F, 8'h00, 4'd9,  8'hFF, 4'b1100, 8'd1, 8'd0, 1'b0);
    op("mod0",  8'h37, 8'h00, 4'd10, 8'h37, 4'b1000, 8'd1, 8'd0, 1'b0);
    op("pass",  8'h00, 8'hA5, 4'd13, 8'hA5, 4'b0100, 8'd1, 8'd0, 1'b0);

    prev_an = an;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      prev_an = an;
    end
    check("disp_sync", 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("disp_an_%0d", i),  32'(an),  32'(anexp[i/4]));
      check($sformatf("disp_seg_%0d", i), 32'(seg), 32'(segexp[i/4]));
      @(negedge clk);
    end
    check("disp_wrap", 32'(an), 32'b1110);

    a = 8'hFF; b = 8'h03; f = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_result", 32'(result), 32'h00);
    check("abort_flags",  32'(flags),  32'h0);
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seg_unit.md
# alu_seg_unit

Parametrised successor to the 4-bit ALU/display block. It takes WIDTH-bit operands and a 4-bit function code under a start/done handshake. Single-cycle operations finish in one cycle; multiply, divide and modulo run iteratively. The result and flags are held in registers, and the result is shown in hex on a time-multiplexed DIGITS-digit seven-segment display. It sits between the board switch/button logic and the display pins.

## Interface
- WIDTH, 8: operand/result width; must satisfy 4 ≤ WIDTH ≤ 4*DIGITS.
- DIGITS, 4: number of multiplexed display digits.
- REFRESH, 50000: clock cycles each digit stays enabled; must be ≥ 1.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- f  in  4  function code.
- start  in  1  request; a, b and f are captured on the accepting edge.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse when result/flags update.
- result  out  WIDTH  last completed result.
- flags  out  4  {V,N,C,Z}: flags[0]=Z, [1]=C, [2]=N, [3]=V.
- seg  out  7  active-low segments, seg[6:0]=g..a.
- an  out  DIGITS  active-low one-hot digit enable.

## Operation
- Function codes (all arithmetic mod 2^WIDTH):
  - 0 add, 1 sub (a-b), 2 and, 3 or, 4 xor, 5 not a.
  - 6 shl a by 1, 7 shr a by 1 (logical).
  - 8 mul (low WIDTH bits), 9 div (a/b quotient), 10 mod (a%b).
  - 11 inc a, 12 dec a, 13 pass b.
  - 14/15 reserved: result 0.
- Codes 8, 9 and 10 are iterative when b≠0. All other codes, and 9/10 with b=0, are single-cycle.
- FSM states:
  - IDLE: start accepted when busy=0.
    - Single-cycle code → result/flags/done written on the same edge; stay IDLE.
    - Iterative code → ITER, busy=1, counter=0.
  - ITER: one shift-add (mul) or restoring-subtract (div/mod) step per cycle.
    - After WIDTH steps: write result/flags, done=1, busy=0, return to IDLE.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - C:
    - add: carry-out.
    - sub: borrow (a<b).
    - shl: a[WIDTH-1]; shr: a[0].
    - mul: upper product half ≠ 0.
    - all other codes: 0.
  - V:
    - add/sub: signed overflow.
    - div/mod by zero: 1.
    - all other codes: 0.
- Divide by zero: quotient all ones, mod result = a, V=1. Both complete single-cycle.
- Display:
  - Shows result in hex; digit i shows result[4i+3:4i], zero-padded above WIDTH.
  - Uses a standard hex 0–F seven-segment decode; result changes are visible only after done.
  - A refresh counter advances the active digit every REFRESH cycles: 0,1,…,DIGITS-1, then wraps to 0. Free-running, independent of FSM state.

## Timing
- Reset values (the cycle after rst is sampled high):
  - busy=0, done=0, result=0, flags=0, FSM=IDLE, refresh counter=0.
  - an = all ones except an[0]=0; seg=7'b1000000 (digit "0").
- Single-cycle op: start high before edge k → done=1 and new result/flags during cycle k..k+1.
- Iterative op: start accepted at edge k → busy=1 after edges k..k+WIDTH-1. At edge k+WIDTH: busy=0, done=1, result/flags valid.
- done is high for exactly one cycle. In the done cycle busy=0, so a start held high is accepted at the next edge. Back-to-back ops are allowed.
- start while busy=1 is ignored; a, b and f changes during ITER do not affect the result.
- rst has priority over everything, including mid-ITER: the operation is aborted and no done pulse is issued.
- Display outputs are registered: an and seg change together, one cycle after the counter wraps.

## Test plan
All scenarios use WIDTH=8, DIGITS=4, REFRESH=4.
- Reset: hold rst 2 cycles → busy=0, done=0, result=0x00, flags=4'b0000, an=4'b1110, seg=7'b1000000.
- Add: a=0xFF, b=0x01, f=0, start 1 cycle → done 1 cycle later, result=0x00, flags=4'b0011; busy never high.
- Multiply: a=0x12, b=0x10, f=8 → busy high exactly 8 cycles, then done, result=0x20, flags=4'b0010. A start pulse with f=0 mid-busy is ignored.
- Divide/mod: a=0x64, b=0x07, f=9 → result=0x0E after 8 cycles; f=10 → 0x02. Divide by zero, a=0x0F, b=0x00, f=9 → done after 1 cycle, result=0xFF, flags=4'b1100.
- Display: after result=0xA5, an cycles 1110→1101→1011→0111→1110, 4 cycles each. seg per digit: 7'b0010010 ("5"), 7'b0001000 ("A"), 7'b1000000, 7'b1000000.
- Reset mid-op: a=0xFF, b=0x03, f=9, assert rst 3 cycles into ITER → next cycle busy=0, result=0x00, and no done pulse for 20 cycles.
